load_store_unit: RTL and testbench

- Sits directly upstream of data_memory, between the execute stage and the memory.
- Accepts byte-addressed load/store requests over a valid/ready handshake and drives data_memory's en/write/addr/data port.
- Sub-word stores use read-modify-write, because data_memory only writes whole words.
- Loads return a sign- or zero-extended result over a valid/ready response handshake.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-wide data_memory.
// Sub-word stores read-modify-write; loads return sign/zero-extended lanes.
`default_nettype none
`timescale 1ns/1ps

module load_store_unit #(
   parameter int WORD_SIZE      = 64,
   parameter int DATA_ADDR_SIZE = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [1:0]                  req_size,
   input  logic                        req_signed,
   input  logic [DATA_ADDR_SIZE+2:0]   req_addr,
   input  logic [WORD_SIZE-1:0]        req_wdata,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [WORD_SIZE-1:0]        resp_data,
   output logic                        resp_err,
   output logic                        mem_en,
   output logic                        mem_write,
   output logic [DATA_ADDR_SIZE-1:0]   mem_addr,
   output logic [WORD_SIZE-1:0]        mem_data,
   input  logic [WORD_SIZE-1:0]        mem_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WT   = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t                      state;
   state_t                      state_nxt;

   logic                        l_write;
   logic [1:0]                  l_size;
   logic                        l_signed;
   logic [DATA_ADDR_SIZE+2:0]   l_addr;
   logic [WORD_SIZE-1:0]        l_wdata;
   logic [WORD_SIZE-1:0]        cap;

   logic                        misaligned;
   logic                        accept;
   logic [5:0]                  lane_shift;
   logic [WORD_SIZE-1:0]        lane_mask;
   logic [WORD_SIZE-1:0]        shifted;
   logic [WORD_SIZE-1:0]        load_val;
   logic [WORD_SIZE-1:0]        merged;

   always_comb begin
      misaligned = 1'b0;
      case (req_size)
         2'b00: misaligned = 1'b0;
         2'b01: misaligned = req_addr[0];
         2'b10: misaligned = |req_addr[1:0];
         2'b11: misaligned = |req_addr[2:0];
      endcase
   end

   assign accept     = (state == IDLE) && req_valid;
   assign lane_shift = {l_addr[2:0], 3'b000};
   assign shifted    = mem_rdata >> lane_shift;

   always_comb begin
      lane_mask = '1;
      load_val  = shifted;
      case (l_size)
         2'b00: begin
            lane_mask = {{(WORD_SIZE-8){1'b0}}, 8'hFF};
            load_val  = {{(WORD_SIZE-8){l_signed & shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            lane_mask = {{(WORD_SIZE-16){1'b0}}, 16'hFFFF};
            load_val  = {{(WORD_SIZE-16){l_signed & shifted[15]}}, shifted[15:0]};
         end
         2'b10: begin
            lane_mask = {{(WORD_SIZE-32){1'b0}}, 32'hFFFF_FFFF};
            load_val  = {{(WORD_SIZE-32){l_signed & shifted[31]}}, shifted[31:0]};
         end
         2'b11: begin
            lane_mask = '1;
            load_val  = shifted;
         end
      endcase
   end

   // Replace only the addressed lanes of the previously read word.
   assign merged = (cap & ~(lane_mask << lane_shift)) | ((l_wdata & lane_mask) << lane_shift);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_en     = 1'b0;
      mem_write  = 1'b0;
      case (state)
         IDLE: begin
            req_ready = rst_n;
            if (req_valid) begin
               if (misaligned) begin
                  state_nxt = RESP;
               end else if (req_write && (req_size == 2'b11)) begin
                  state_nxt = WR;
               end else begin
                  state_nxt = RD;
               end
            end
         end
         RD: begin
            mem_en    = 1'b1;
            state_nxt = WT;
         end
         WT: begin
            state_nxt = l_write ? WR : RESP;
         end
         WR: begin
            mem_en    = 1'b1;
            mem_write = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_write   <= 1'b0;
         l_size    <= 2'b00;
         l_signed  <= 1'b0;
         l_addr    <= '0;
         l_wdata   <= '0;
         cap       <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else if (accept) begin
         l_write   <= req_write;
         l_size    <= req_size;
         l_signed  <= req_signed;
         l_addr    <= req_addr;
         l_wdata   <= req_wdata;
         resp_data <= '0;
         resp_err  <= misaligned;
      end else if (state == WT) begin
         cap <= mem_rdata;
         if (!l_write) begin
            resp_data <= load_val;
         end
      end
   end

   assign mem_addr = l_addr[DATA_ADDR_SIZE+2:3];
   assign mem_data = (state != WR) ? '0 : ((l_size == 2'b11) ? l_wdata : merged);

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a behavioural data_memory.
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [10:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [63:0] resp_data;
   logic        resp_err;
   logic        mem_en;
   logic        mem_write;
   logic [7:0]  mem_addr;
   logic [63:0] mem_data;
   logic [63:0] mem_rdata = '0;

   logic [63:0] mem [256] = '{default: 64'd0};

   int          total = 0;
   int          bad = 0;
   int          lat;
   logic [15:0] trace;
   logic        anyen;

   always #5 clk = ~clk;

   load_store_unit #(.WORD_SIZE(64), .DATA_ADDR_SIZE(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_rdata  (mem_rdata)
   );

   // data_memory: write commits at the edge, read data appears the cycle after
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_write) mem[mem_addr] <= mem_data;
         else           mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; returns at the falling edge where resp_valid is seen.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [10:0] a, input logic [63:0] wd);
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      check("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat   = 1;
      trace = '0;
      anyen = 1'b0;
      while (!resp_valid && lat < 20) begin
         trace = {trace[13:0], mem_en, mem_write};
         anyen = anyen | mem_en;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      anyen = anyen | mem_en;
      if (!resp_valid) check("resp_timeout", 64'd0, 64'd1);
   endtask

   task automatic finish_resp(input int hold);
      logic [63:0] d;
      d = resp_data;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", {63'd0, resp_valid}, 64'd1);
         check("hold_data", resp_data, d);
         check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                     input logic [10:0] a, input logic [63:0] wd,
                     input int exp_lat, input logic [63:0] exp_data, input logic exp_err);
      issue(w, sz, sg, a, wd);
      check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
      check({tag, ".data"}, resp_data, exp_data);
      check({tag, ".err"}, {63'd0, resp_err}, {63'd0, exp_err});
      finish_resp(0);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("reset_ctrl", {59'd0, req_ready, resp_valid, resp_err, mem_en, mem_write}, 64'd0);
      check("reset_data", resp_data, 64'd0);
      check("reset_mem", mem_data | {56'd0, mem_addr}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {63'd0, req_ready}, 64'd1);

      op("st_d0", 1'b1, 2'b11, 1'b0, 11'h000, 64'h0123456789ABCDEF, 2, 64'd0, 1'b0);
      op("ld_d0", 1'b0, 2'b11, 1'b0, 11'h000, 64'd0, 3, 64'h0123456789ABCDEF, 1'b0);

      op("st_b7fb", 1'b1, 2'b00, 1'b0, 11'h7FB, 64'h0000000000000080, 4, 64'd0, 1'b0);
      op("ld_bs7fb", 1'b0, 2'b00, 1'b1, 11'h7FB, 64'd0, 3, 64'hFFFFFFFFFFFFFF80, 1'b0);
      op("ld_bu7fb", 1'b0, 2'b00, 1'b0, 11'h7FB, 64'd0, 3, 64'h0000000000000080, 1'b0);
      op("ld_d7f8", 1'b0, 2'b11, 1'b0, 11'h7F8, 64'd0, 3, 64'h0000000080000000, 1'b0);

      op("st_d008", 1'b1, 2'b11, 1'b0, 11'h008, 64'hFFFFFFFFFFFFFFFF, 2, 64'd0, 1'b0);
      issue(1'b1, 2'b01, 1'b0, 11'h00A, 64'h000000000000BEEF);
      check("st_h00a.lat", 64'(lat), 64'd4);
      check("st_h00a.mem_seq", {48'd0, trace}, 64'h0000000000000023);
      finish_resp(0);
      op("ld_d008", 1'b0, 2'b11, 1'b0, 11'h008, 64'd0, 3, 64'hFFFFFFFFBEEFFFFF, 1'b0);
      op("ld_hs00a", 1'b0, 2'b01, 1'b1, 11'h00A, 64'd0, 3, 64'hFFFFFFFFFFFFBEEF, 1'b0);
      op("ld_wu008", 1'b0, 2'b10, 1'b0, 11'h008, 64'd0, 3, 64'h00000000BEEFFFFF, 1'b0);

      issue(1'b0, 2'b10, 1'b1, 11'h006, 64'd0);
      check("mis_w006.lat", 64'(lat), 64'd1);
      check("mis_w006.err", {63'd0, resp_err}, 64'd1);
      check("mis_w006.data", resp_data, 64'd0);
      check("mis_w006.no_mem", {63'd0, anyen}, 64'd0);
      finish_resp(0);
      op("mis_h009", 1'b1, 2'b01, 1'b0, 11'h009, 64'h1234, 1, 64'd0, 1'b1);
      op("ld_after_mis", 1'b0, 2'b11, 1'b0, 11'h008, 64'd0, 3, 64'hFFFFFFFFBEEFFFFF, 1'b0);

      // Backpressure: a second request waits while the response is held
      issue(1'b0, 2'b11, 1'b0, 11'h000, 64'd0);
      check("bp_first.data", resp_data, 64'h0123456789ABCDEF);
      req_write  = 1'b0;
      req_size   = 2'b10;
      req_signed = 1'b1;
      req_addr   = 11'h000;
      req_valid  = 1'b1;
      finish_resp(5);
      check("bp_after_hs.valid", {63'd0, resp_valid}, 64'd0);
      check("bp_after_hs.ready", {63'd0, req_ready}, 64'd1);
      issue(1'b0, 2'b10, 1'b1, 11'h000, 64'd0);
      check("bp_second.lat", 64'(lat), 64'd3);
      check("bp_second.data", resp_data, 64'hFFFFFFFF89ABCDEF);
      finish_resp(0);

      // Reset during the write phase of a sub-word store
      op("st_d010", 1'b1, 2'b11, 1'b0, 11'h010, 64'h1111111111111111, 2, 64'd0, 1'b0);
      req_write  = 1'b1;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 11'h011;
      req_wdata  = 64'h00000000000000AA;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_wr.in_wr", {62'd0, mem_en, mem_write}, 64'd3);
      rst_n = 1'b0;
      #1;
      check("rst_wr.ctrl", {59'd0, req_ready, resp_valid, resp_err, mem_en, mem_write}, 64'd0);
      check("rst_wr.data", resp_data, 64'd0);
      check("rst_wr.mem", mem_data | {56'd0, mem_addr}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_wr.ready", {63'd0, req_ready}, 64'd1);
      op("ld_d010", 1'b0, 2'b11, 1'b0, 11'h010, 64'd0, 3, 64'h1111111111111111, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

`default_nettype wire
